ps2_key_receiver: RTL and testbench
===================================

Name: ps2_key_receiver

Overview:
- Keyboard front end that drives the key_reg/sample input of the data Memory block in the multicycle processor.
- Deserialises PS/2 device-to-host frames, checks them, presents the byte on key_reg and strobes sample for one cycle.
- Runs in the processor clock domain. ps2_clk is oversampled as a data signal, never used as a clock.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on ps2_clk and ps2_data; minimum 2.
- TIMEOUT_CYCLES, 5000, clocks without a ps2_clk falling edge before a partial frame is aborted.
- CNT_W, 16, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- resetn  in  1  synchronous, active-low reset, sampled on the rising edge of clock.
- ps2_clk  in  1  raw PS/2 clock line, asynchronous.
- ps2_data  in  1  raw PS/2 data line, asynchronous.
- key_reg  out  8  last valid received byte; held until the next valid byte.
- sample  out  1  one-cycle pulse: key_reg was updated this cycle.
- frame_err  out  1  one-cycle pulse on parity, stop-bit or timeout error.
- busy  out  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset (resetn=0 at a clock edge):
  - state=IDLE, key_reg=8'h00, sample=0, frame_err=0, busy=0.
  - Synchroniser flops and previous-clock flop load 1 (idle bus level). Bit counter and timeout counter load 0.
  - Reset has priority over everything. Reset mid-frame discards the partial frame with no sample and no frame_err.
- Synchronisation and edge detection:
  - Both lines pass through SYNC_STAGES flops.
  - fall = prev_clk & ~sync_clk, where prev_clk is the synced clock delayed by one cycle.
  - ps2_data is read from its synced copy in the same cycle fall is true.
- Frame format: start(0), D0..D7 LSB first, odd parity, stop(1). All bits are taken on ps2_clk falling edges.
- FSM:
  - IDLE: on fall with data=0 -> DATA, bitcnt=0. On fall with data=1 (glitch), stay in IDLE with no error.
  - DATA: on fall, shift data into shreg[7] with a right shift and increment bitcnt. After the 8th bit -> PARITY.
  - PARITY: on fall, store parity bit -> STOP.
  - STOP: on fall -> IDLE.
    - If stop=1 and ^{shreg,parity}==1: key_reg<=shreg, sample=1 for exactly the next cycle.
    - Otherwise frame_err=1 for one cycle and key_reg is unchanged.
- Latency: sample rises at the clock edge that consumes the stop-bit fall, which is SYNC_STAGES+1 clocks after the raw ps2_clk falling edge.
- Timeout:
  - The counter clears on every fall and in IDLE, and increments each cycle in the other states.
  - When it reaches TIMEOUT_CYCLES-1: state -> IDLE, frame_err pulses, no sample.
  - If a fall occurs in the same cycle the counter reaches the limit, the fall wins and the counter clears.
- sample and frame_err are never both high in the same cycle. Both default to 0 in every cycle not listed above.
- A new start bit is accepted on the first fall after returning to IDLE; no dead time is required.

Optional Feature:
- Macro: KEY_BREAK_FILTER_EN.
- Defined:
  - A valid byte 8'hF0 sets break_pending and produces no sample; key_reg is unchanged.
  - The next valid byte clears break_pending and produces no sample; key_reg is unchanged.
  - frame_err or timeout also clears break_pending. Reset clears it.
  - 8'hE0 is treated as an ordinary byte.
  - Net effect: only make codes reach the Memory.
- Undefined:
  - Every valid byte, including F0, updates key_reg and pulses sample.
  - No break_pending register exists.

Test Plan:
1. Reset -> key_reg=8'h00, sample=0, frame_err=0, busy=0. Wiggle ps2_data with ps2_clk held high -> no change on any output.
2. Valid frame for 8'h1C with parity=0 and stop=1 -> busy high from the start bit. key_reg=8'h1C with one sample pulse SYNC_STAGES+1 clocks after the stop falling edge, then busy=0.
3. Frame 8'h1C with parity=1 -> one frame_err pulse, no sample, key_reg keeps its prior value. Repeat with stop=0 -> same response.
4. Start plus 3 data bits, then ps2_clk held high -> frame_err pulses TIMEOUT_CYCLES-1 clocks after the last fall and busy=0. A following valid 8'h5A frame gives key_reg=8'h5A with one sample.
5. Assert resetn=0 for one clock after 5 data bits -> IDLE with no pulses. A following valid 8'h23 frame is received correctly.
6. Frames F0 then 1C:
   - With KEY_BREAK_FILTER_EN: zero sample pulses, key_reg unchanged. A subsequent 1C gives one sample.
   - Without it: two sample pulses, key_reg ends at 8'h1C.

Source files
------------

// File: rtl/ps2_key_receiver.sv
// ps2_key_receiver: PS/2 device-to-host byte receiver, oversampled in the clock domain.
// Define KEY_BREAK_FILTER_EN to swallow F0-prefixed break codes so only make codes are presented.
module ps2_key_receiver #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int CNT_W          = 16
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_reg,
    output logic       sample,
    output logic       frame_err,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    state_t state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_q, sclk_d, sdat_q, sdat_d;
    logic prev_q, prev_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [7:0] shreg_q, shreg_d, key_q, key_d;
    logic par_q, par_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic sample_q, sample_d, err_q, err_d, busy_q, busy_d;
    logic fall, din, frame_ok;
`ifdef KEY_BREAK_FILTER_EN
    logic brk_q, brk_d;
`endif
    assign fall     = prev_q & ~sclk_q[SYNC_STAGES-1];
    assign din      = sdat_q[SYNC_STAGES-1];
    assign frame_ok = din & (^{shreg_q, par_q});
    always_comb begin
        sclk_d   = {sclk_q[SYNC_STAGES-2:0], ps2_clk};
        sdat_d   = {sdat_q[SYNC_STAGES-2:0], ps2_data};
        prev_d   = sclk_q[SYNC_STAGES-1];
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        par_d    = par_q;
        key_d    = key_q;
        sample_d = 1'b0;
        err_d    = 1'b0;
        cnt_d    = (state_q == IDLE || fall) ? '0 : cnt_q + 1'b1;
`ifdef KEY_BREAK_FILTER_EN
        brk_d    = brk_q;
`endif
        if (fall) begin
            case (state_q)
                IDLE: begin
                    state_d  = din ? IDLE : DATA;
                    bitcnt_d = 3'd0;
                end
                DATA: begin
                    shreg_d  = {din, shreg_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    state_d  = (bitcnt_q == 3'd7) ? PARITY : DATA;
                end
                PARITY: begin
                    par_d   = din;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    err_d   = ~frame_ok;
`ifdef KEY_BREAK_FILTER_EN
                    brk_d = frame_ok & ~brk_q & (shreg_q == 8'hF0);
                    if (frame_ok && !brk_q && shreg_q != 8'hF0) begin
                        key_d    = shreg_q;
                        sample_d = 1'b1;
                    end
`else
                    if (frame_ok) begin
                        key_d    = shreg_q;
                        sample_d = 1'b1;
                    end
`endif
                end
            endcase
        end else if (state_q != IDLE && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            // stalled partial frame: abandon it so the next start bit is seen
            state_d = IDLE;
            err_d   = 1'b1;
`ifdef KEY_BREAK_FILTER_EN
            brk_d   = 1'b0;
`endif
        end
        busy_d = (state_d != IDLE);
    end
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q  <= IDLE;
            sclk_q   <= '1;
            sdat_q   <= '1;
            prev_q   <= 1'b1;
            bitcnt_q <= 3'd0;
            shreg_q  <= 8'h00;
            par_q    <= 1'b0;
            key_q    <= 8'h00;
            cnt_q    <= '0;
            sample_q <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
`ifdef KEY_BREAK_FILTER_EN
            brk_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sclk_q   <= sclk_d;
            sdat_q   <= sdat_d;
            prev_q   <= prev_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            par_q    <= par_d;
            key_q    <= key_d;
            cnt_q    <= cnt_d;
            sample_q <= sample_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
`ifdef KEY_BREAK_FILTER_EN
            brk_q    <= brk_d;
`endif
        end
    end
    assign key_reg   = key_q;
    assign sample    = sample_q;
    assign frame_err = err_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_ps2_key_receiver.sv
// tb_ps2_key_receiver: vector table, corner sequences and random frames against a byte-level model.
module tb_ps2_key_receiver;
    localparam int SYNC = 2;
    localparam int TMO  = 5000;
    logic clk = 1'b0, resetn = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
    logic [7:0] key_reg;
    logic sample, frame_err, busy;
    int checks = 0, failures = 0;
    int cyc = 0, n_samp = 0, n_err = 0, samp_cyc = 0, err_cyc = 0, fall_cyc = 0;
    bit both_high = 1'b0;
    logic [7:0] key_m;
    bit brk_m;

    ps2_key_receiver #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO), .CNT_W(16)) dut (
        .clock(clk), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .key_reg(key_reg), .sample(sample), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (sample) begin n_samp++; samp_cyc = cyc; end
        if (frame_err) begin n_err++; err_cyc = cyc; end
        if (sample && frame_err) both_high = 1'b1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic ps2_bit(input logic b, input int h);
        @(negedge clk);
        ps2_data = b;
        repeat (h) @(negedge clk);
        ps2_clk = 1'b0;
        fall_cyc = cyc;
        repeat (h) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop,
                              input int h, input int n);
        logic [10:0] bits;
        bits = {stop, ~(^d) ^ bad_par, d, 1'b0};
        for (int i = 0; i < n; i++) ps2_bit(bits[i], h);
        repeat (8) @(negedge clk);
    endtask

    // byte-level reference: a frame is either discarded as an error or delivers a byte
    task automatic model(input logic [7:0] d, input bit ok, output int s, output int e);
        s = 0;
        e = 0;
        if (!ok) begin
            e = 1;
            brk_m = 1'b0;
        end else begin
`ifdef KEY_BREAK_FILTER_EN
            if (brk_m) brk_m = 1'b0;
            else if (d == 8'hF0) brk_m = 1'b1;
            else begin key_m = d; s = 1; end
`else
            key_m = d;
            s = 1;
`endif
        end
    endtask

    typedef struct {
        logic [7:0] d;
        logic       bad_par;
        logic       stop;
        logic [7:0] exp_key;
        int         exp_s;
        int         exp_e;
    } vec_t;
    vec_t vecs[12];

    initial begin
        int s0, e0, es, ee, waited;
        vecs[0] = '{8'h1C, 1'b0, 1'b1, 8'h1C, 1, 0};
        vecs[1] = '{8'h5A, 1'b1, 1'b1, 8'h1C, 0, 1};
        vecs[2] = '{8'h5A, 1'b0, 1'b0, 8'h1C, 0, 1};
        vecs[3] = '{8'h5A, 1'b0, 1'b1, 8'h5A, 1, 0};
`ifdef KEY_BREAK_FILTER_EN
        vecs[4] = '{8'hF0, 1'b0, 1'b1, 8'h5A, 0, 0};
        vecs[5] = '{8'h1C, 1'b0, 1'b1, 8'h5A, 0, 0};
`else
        vecs[4] = '{8'hF0, 1'b0, 1'b1, 8'hF0, 1, 0};
        vecs[5] = '{8'h1C, 1'b0, 1'b1, 8'h1C, 1, 0};
`endif
        vecs[6] = '{8'h1C, 1'b0, 1'b1, 8'h1C, 1, 0};
        vecs[7] = '{8'h00, 1'b0, 1'b1, 8'h00, 1, 0};
        vecs[8] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1, 0};
`ifdef KEY_BREAK_FILTER_EN
        vecs[9]  = '{8'hF0, 1'b0, 1'b1, 8'hFF, 0, 0};
        vecs[10] = '{8'h1C, 1'b1, 1'b1, 8'hFF, 0, 1};
`else
        vecs[9]  = '{8'hF0, 1'b0, 1'b1, 8'hF0, 1, 0};
        vecs[10] = '{8'h1C, 1'b1, 1'b1, 8'hF0, 0, 1};
`endif
        vecs[11] = '{8'h2B, 1'b0, 1'b1, 8'h2B, 1, 0};

        repeat (3) @(negedge clk);
        chk("reset_key", key_reg, 8'h00);
        chk("reset_sample", sample, 0);
        chk("reset_err", frame_err, 0);
        chk("reset_busy", busy, 0);
        resetn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            ps2_data = ~ps2_data;
            repeat (3) @(negedge clk);
        end
        ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        chk("wiggle_samples", n_samp, 0);
        chk("wiggle_errs", n_err, 0);
        chk("wiggle_busy", busy, 0);
        chk("wiggle_key", key_reg, 8'h00);

        // latency and busy on a hand-built 1C frame
        s0 = n_samp;
        ps2_bit(1'b0, 4);
        chk("busy_after_start", busy, 1);
        for (int i = 0; i < 8; i++) ps2_bit(i inside {2, 3, 4}, 4);
        ps2_bit(1'b0, 4);
        ps2_bit(1'b1, 4);
        repeat (8) @(negedge clk);
        chk("lat_samples", n_samp - s0, 1);
        chk("lat_cycles", samp_cyc - fall_cyc, SYNC + 1);
        chk("lat_key", key_reg, 8'h1C);
        chk("lat_busy_end", busy, 0);

        for (int v = 0; v < 12; v++) begin
            s0 = n_samp;
            e0 = n_err;
            send_frame(vecs[v].d, vecs[v].bad_par, vecs[v].stop, 3, 11);
            chk($sformatf("vec%0d_samples", v), n_samp - s0, vecs[v].exp_s);
            chk($sformatf("vec%0d_errs", v), n_err - e0, vecs[v].exp_e);
            chk($sformatf("vec%0d_key", v), key_reg, vecs[v].exp_key);
            chk($sformatf("vec%0d_busy", v), busy, 0);
        end

        // timeout: start + 3 data bits then silence
        s0 = n_samp;
        e0 = n_err;
        send_frame(8'h5A, 1'b0, 1'b1, 3, 4);
        waited = 0;
        while (n_err == e0 && waited < TMO + 100) begin
            @(negedge clk);
            waited++;
        end
        chk("tmo_errs", n_err - e0, 1);
        chk("tmo_window", (err_cyc - fall_cyc >= TMO - 1) && (err_cyc - fall_cyc <= TMO + SYNC + 1), 1);
        chk("tmo_samples", n_samp - s0, 0);
        repeat (2) @(negedge clk);
        chk("tmo_busy", busy, 0);
        send_frame(8'h5A, 1'b0, 1'b1, 3, 11);
        chk("post_tmo_key", key_reg, 8'h5A);
        chk("post_tmo_samples", n_samp - s0, 1);

        // reset after 5 data bits
        s0 = n_samp;
        e0 = n_err;
        send_frame(8'h23, 1'b0, 1'b1, 3, 6);
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        repeat (20) @(negedge clk);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_pulses", (n_samp - s0) + (n_err - e0), 0);
        chk("rst_mid_key", key_reg, 8'h00);
        send_frame(8'h23, 1'b0, 1'b1, 3, 11);
        chk("post_rst_key", key_reg, 8'h23);
        chk("post_rst_samples", n_samp - s0, 1);

        key_m = 8'h23;
        brk_m = 1'b0;
        for (int r = 0; r < 40; r++) begin
            logic [7:0] d;
            int kind;
            d = 8'($urandom);
            if (r % 5 == 0) d = 8'hF0;
            kind = $urandom_range(0, 3);
            s0 = n_samp;
            e0 = n_err;
            model(d, kind < 2, es, ee);
            send_frame(d, kind == 2, kind != 3, $urandom_range(2, 5), 11);
            repeat ($urandom_range(0, 6)) @(negedge clk);
            chk($sformatf("rnd%0d_samples", r), n_samp - s0, es);
            chk($sformatf("rnd%0d_errs", r), n_err - e0, ee);
            chk($sformatf("rnd%0d_key", r), key_reg, key_m);
        end

        chk("never_both_pulses", both_high, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
